// File: rtl/ncl_ring_sequencer_pkg.sv
// Shared types for the NCL ring sequencer: FSM state encoding and dual-rail code points.
package ncl_ring_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE_DATA,
    ST_WAIT_DATA,
    ST_DRIVE_NULL,
    ST_WAIT_NULL,
    ST_FINISH,
    ST_ERR
  } state_t;

  localparam logic [1:0] NULL_2R  = 2'b00;
  localparam logic [1:0] DATA0_2R = 2'b01;
  localparam logic [1:0] DATA1_2R = 2'b10;

  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE) && (s != ST_ERR);
  endfunction

endpackage

// File: rtl/ncl_sync.sv
// Multi-flop synchronizer for asynchronous NCL completion/data inputs.
module ncl_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned W      = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ncl_ring_sequencer.sv
// Drives DATA1/NULL increment wavefronts into an NCL counter ring and sinks its MS carry.
module ncl_ring_sequencer
  import ncl_ring_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] target,
  output logic [1:0]       carryin,
  input  logic             carryinCOMP,
  input  logic [1:0]       carryout,
  output logic             carryoutCOMP,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             timeout_err,
  output logic [CNT_W-1:0] inc_count
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_target;
  logic             r_stop;
  logic [TO_W-1:0]  r_wait_cnt;

  logic             w_comp;
  logic [1:0]       w_cout;
  logic [CNT_W-1:0] w_inc_next;
  logic             w_stop_now;

  ncl_sync #(.STAGES(SYNC_STAGES), .W(1)) u_sync_comp (
    .i_clk(clk), .i_rst(init), .i_d(carryinCOMP), .o_q(w_comp)
  );

  ncl_sync #(.STAGES(SYNC_STAGES), .W(2)) u_sync_cout (
    .i_clk(clk), .i_rst(init), .i_d(carryout), .o_q(w_cout)
  );

  assign w_inc_next = (inc_count == '1) ? inc_count : inc_count + 1'b1;
  assign w_stop_now = r_stop | stop;

  // carryin is updated on the transition into each DRIVE state so the
  // completion-to-NULL latency is exactly SYNC_STAGES + 1 edges.
  always_ff @(posedge clk) begin
    if (init) begin
      r_state     <= ST_IDLE;
      carryin     <= NULL_2R;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      inc_count   <= '0;
      r_target    <= '0;
      r_stop      <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (is_busy(r_state) && stop) r_stop <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            inc_count <= '0;
            r_stop    <= 1'b0;
            busy      <= 1'b1;
            if (target != '0) begin
              r_target <= target;
              carryin  <= DATA1_2R;
              r_state  <= ST_DRIVE_DATA;
            end else begin
              done    <= 1'b1;
              r_state <= ST_FINISH;
            end
          end
        end
        ST_DRIVE_DATA: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (w_comp) begin
            carryin <= NULL_2R;
            r_state <= ST_DRIVE_NULL;
          end else if (r_wait_cnt == TO_LAST) begin
            carryin     <= NULL_2R;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            r_state     <= ST_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_DRIVE_NULL: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT_NULL;
        end
        ST_WAIT_NULL: begin
          if (!w_comp) begin
            inc_count <= w_inc_next;
            if ((w_inc_next == r_target) || w_stop_now) begin
              done    <= 1'b1;
              r_stop  <= 1'b0;
              r_state <= ST_FINISH;
            end else begin
              carryin <= DATA1_2R;
              r_state <= ST_DRIVE_DATA;
            end
          end else if (r_wait_cnt == TO_LAST) begin
            carryin     <= NULL_2R;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            r_state     <= ST_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          busy    <= 1'b0;
          r_stop  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          carryin <= NULL_2R;
          busy    <= 1'b0;
        end
        default: begin
          carryin <= NULL_2R;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Carry-out sink runs regardless of FSM state, including ERR.
  always_ff @(posedge clk) begin
    if (init) begin
      carryoutCOMP <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      carryoutCOMP <= (w_cout != NULL_2R);
      if ((r_state == ST_IDLE) && start) overflow <= 1'b0;
      else if (w_cout == DATA1_2R)       overflow <= 1'b1;
    end
  end

endmodule
